// File: rtl/spi_oled_axil_slave.sv
// AXI4-Lite register file driving the OLED control pins, plus a 9-bit mode-0 SPI transmitter.
// SPI FSM:  ST_IDLE  | no transfer, cs_n high
//           ST_SETUP | cs_n low, dc and first bit presented, one half-period
//           ST_SHIFT | 16 half-periods, sclk toggles, sdin advances on falling edge
//           ST_HOLD  | sclk low for one half-period before cs_n returns high
module spi_oled_axil_slave #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY,
  output logic                    oled_sclk,
  output logic                    oled_sdin,
  output logic                    oled_cs_n,
  output logic                    oled_dc,
  output logic                    oled_res_n,
  output logic                    busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD} state_t;

  localparam logic [2:0] IDX_CTRL    = 3'd0;
  localparam logic [2:0] IDX_CLKDIV  = 3'd1;
  localparam logic [2:0] IDX_TXDATA  = 3'd2;
  localparam logic [2:0] IDX_SCRATCH = 3'd3;
  localparam logic [2:0] IDX_STATUS  = 3'd4;

  logic                  awready_q, awready_d;
  logic                  bvalid_q,  bvalid_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q,  rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
  logic [DATA_WIDTH-1:0] ctrl_q,    ctrl_d;
  logic [DATA_WIDTH-1:0] clkdiv_q,  clkdiv_d;
  logic [DATA_WIDTH-1:0] txdata_q,  txdata_d;
  logic [DATA_WIDTH-1:0] scratch_q, scratch_d;
  logic                  overflow_q, overflow_d;
  state_t                state_q,   state_d;
  logic [DIV_WIDTH-1:0]  cnt_q,     cnt_d;
  logic [DIV_WIDTH-1:0]  div_q,     div_d;
  logic [3:0]            half_q,    half_d;
  logic [7:0]            shreg_q,   shreg_d;
  logic                  sclk_q,    sclk_d;
  logic                  sdin_q,    sdin_d;
  logic                  cs_n_q,    cs_n_d;
  logic                  dc_q,      dc_d;
  logic                  busy_q,    busy_d;

  logic                  wr_fire, rd_fire, tx_wr, launch;
  logic [2:0]            wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] wr_old, wr_new;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  function automatic logic [DATA_WIDTH-1:0] apply_strb(input logic [DATA_WIDTH-1:0]   old_v,
                                                       input logic [DATA_WIDTH-1:0]   wr_v,
                                                       input logic [DATA_WIDTH/8-1:0] strb);
    logic [DATA_WIDTH-1:0] res;
    res = old_v;
    for (int i = 0; i < DATA_WIDTH/8; i++) begin
      if (strb[i]) res[8*i +: 8] = wr_v[8*i +: 8];
    end
    return res;
  endfunction

  assign wr_fire = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_fire = arready_q & S_AXI_ARVALID;
  assign wr_idx  = S_AXI_AWADDR[4:2];
  assign rd_idx  = S_AXI_ARADDR[4:2];
  assign tx_wr   = wr_fire && (wr_idx == IDX_TXDATA) && S_AXI_WSTRB[0];
  assign launch  = tx_wr && ctrl_q[0] && !busy_q;

  always_comb begin
    wr_old = '0;
    case (wr_idx)
      IDX_CTRL:    wr_old = ctrl_q;
      IDX_CLKDIV:  wr_old = clkdiv_q;
      IDX_TXDATA:  wr_old = txdata_q;
      IDX_SCRATCH: wr_old = scratch_q;
      default:     wr_old = '0;
    endcase
    wr_new = apply_strb(wr_old, S_AXI_WDATA, S_AXI_WSTRB);
  end

  always_comb begin
    awready_d  = S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !awready_q;
    bvalid_d   = bvalid_q;
    arready_d  = S_AXI_ARVALID && !rvalid_q && !arready_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    ctrl_d     = ctrl_q;
    clkdiv_d   = clkdiv_q;
    txdata_d   = txdata_q;
    scratch_d  = scratch_q;
    overflow_d = overflow_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    half_d     = half_q;
    shreg_d    = shreg_q;
    sclk_d     = sclk_q;
    sdin_d     = sdin_q;
    cs_n_d     = cs_n_q;
    dc_d       = dc_q;
    busy_d     = busy_q;

    if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
    if (wr_fire) begin
      bvalid_d = 1'b1;
      case (wr_idx)
        IDX_CTRL:    ctrl_d     = wr_new;
        IDX_CLKDIV:  clkdiv_d   = wr_new;
        IDX_TXDATA:  txdata_d   = wr_new;
        IDX_SCRATCH: scratch_d  = wr_new;
        IDX_STATUS:  overflow_d = 1'b0;
        default:     ;
      endcase
    end
    if (tx_wr && ctrl_q[0] && busy_q) overflow_d = 1'b1;

    // Read mux sees pre-write state, so a STATUS read racing a launch reports idle.
    if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
    if (rd_fire) begin
      rvalid_d = 1'b1;
      case (rd_idx)
        IDX_CTRL:    rdata_d = ctrl_q;
        IDX_CLKDIV:  rdata_d = clkdiv_q;
        IDX_TXDATA:  rdata_d = txdata_q;
        IDX_SCRATCH: rdata_d = scratch_q;
        IDX_STATUS:  rdata_d = {{(DATA_WIDTH-2){1'b0}}, overflow_q, busy_q};
        default:     rdata_d = '0;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d = ST_SETUP;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          dc_d    = wr_new[8];
          sdin_d  = wr_new[7];
          shreg_d = wr_new[7:0];
          div_d   = clkdiv_q[DIV_WIDTH-1:0];
          cnt_d   = clkdiv_q[DIV_WIDTH-1:0];
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_SHIFT;
          cnt_d   = div_q;
          half_d  = 4'd0;
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      ST_SHIFT: begin
        if (cnt_q == '0) begin
          cnt_d  = div_q;
          half_d = half_q + 4'd1;
          if (!half_q[0]) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d  = 1'b0;
            sdin_d  = shreg_q[6];
            shreg_d = {shreg_q[6:0], 1'b0};
            if (half_q == 4'd15) state_d = ST_HOLD;
          end
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          sdin_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      awready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      ctrl_q     <= '0;
      clkdiv_q   <= '0;
      txdata_q   <= '0;
      scratch_q  <= '0;
      overflow_q <= 1'b0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      half_q     <= '0;
      shreg_q    <= '0;
      sclk_q     <= 1'b0;
      sdin_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      dc_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      awready_q  <= awready_d;
      bvalid_q   <= bvalid_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      ctrl_q     <= ctrl_d;
      clkdiv_q   <= clkdiv_d;
      txdata_q   <= txdata_d;
      scratch_q  <= scratch_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      half_q     <= half_d;
      shreg_q    <= shreg_d;
      sclk_q     <= sclk_d;
      sdin_q     <= sdin_d;
      cs_n_q     <= cs_n_d;
      dc_q       <= dc_d;
      busy_q     <= busy_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid_q;
  assign oled_sclk     = sclk_q;
  assign oled_sdin     = sdin_q;
  assign oled_cs_n     = cs_n_q;
  assign oled_dc       = dc_q;
  assign oled_res_n    = ctrl_q[1];
  assign busy          = busy_q;

endmodule

// File: tb/tb_spi_oled_axil_slave.sv
// Directed bench for spi_oled_axil_slave: AXI scoreboards plus an SPI frame monitor.
module tb_spi_oled_axil_slave;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [4:0]  S_AXI_AWADDR;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [4:0]  S_AXI_ARADDR;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic        oled_sclk, oled_sdin, oled_cs_n, oled_dc, oled_res_n, busy;

  spi_oled_axil_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .oled_sclk(oled_sclk), .oled_sdin(oled_sdin), .oled_cs_n(oled_cs_n),
    .oled_dc(oled_dc), .oled_res_n(oled_res_n), .busy(busy)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    int         busy_n;
    int         low_n;
    int         nbits;
    int         period;
    int         bad;
    logic       dc;
    logic [7:0] bits;
  } frame_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [1:0]  bresp_q[$];
  logic [33:0] rexp_q[$];
  frame_t      exp_fq[$];
  frame_t      rx_q[$];

  frame_t cur;
  bit     active = 1'b0;
  logic   sclk_prev = 1'b0;
  int     cyc = 0;
  int     first_rise = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  // Frame monitor: one entry per cs_n low window, aborted windows are dropped.
  always @(negedge ACLK) begin
    cyc++;
    if (ARESET) begin
      active    = 1'b0;
      sclk_prev = 1'b0;
    end else begin
      if (!active && !oled_cs_n) begin
        active = 1'b1;
        cur.busy_n = 0; cur.low_n = 0; cur.nbits = 0; cur.period = 0; cur.bad = 0;
        cur.dc = oled_dc; cur.bits = 8'h00;
      end
      if (active) begin
        if (oled_cs_n) begin
          if (busy) cur.bad++;
          rx_q.push_back(cur);
          active = 1'b0;
        end else begin
          cur.low_n++;
          if (busy) cur.busy_n++;
          if (oled_dc !== cur.dc) cur.bad++;
          if (oled_sclk && !sclk_prev) begin
            cur.bits = {cur.bits[6:0], oled_sdin};
            if (cur.nbits == 0) first_rise = cyc;
            else if (cur.nbits == 1) cur.period = cyc - first_rise;
            cur.nbits++;
          end
        end
      end
      sclk_prev = oled_sclk;
    end
  end

  task automatic expect_frame(input logic dc, input logic [7:0] b, input int h);
    frame_t f;
    f.busy_n = 18*h; f.low_n = 18*h; f.nbits = 8; f.period = 2*h; f.bad = 0;
    f.dc = dc; f.bits = b;
    exp_fq.push_back(f);
  endtask

  task automatic wait_frame(input string tag);
    frame_t e, r;
    int n = 0;
    while (rx_q.size() == 0 && n < 2000) begin @(negedge ACLK); n++; end
    check({tag, "_arrived"}, 32'(rx_q.size() != 0), 32'd1);
    if (rx_q.size() != 0 && exp_fq.size() != 0) begin
      r = rx_q.pop_front();
      e = exp_fq.pop_front();
      check({tag, "_busy_cycles"}, r.busy_n, e.busy_n);
      check({tag, "_cs_low_cycles"}, r.low_n, e.low_n);
      check({tag, "_nbits"}, r.nbits, e.nbits);
      check({tag, "_sclk_period"}, r.period, e.period);
      check({tag, "_dc"}, 32'(r.dc), 32'(e.dc));
      check({tag, "_bits"}, 32'(r.bits), 32'(e.bits));
      check({tag, "_glitches"}, r.bad, e.bad);
    end
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input string tag);
    int n;
    bresp_q.push_back(2'b00);
    @(negedge ACLK);
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!S_AXI_AWREADY && n < 20);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    n = 0;
    while (!S_AXI_BVALID && n < 20) begin @(negedge ACLK); n++; end
    check({tag, "_bresp"}, {29'd0, S_AXI_BVALID, S_AXI_BRESP}, {29'd0, 1'b1, bresp_q.pop_front()});
  endtask

  task automatic axi_read(input logic [4:0] a, input logic [31:0] exp, input string tag);
    int n;
    logic [33:0] e;
    rexp_q.push_back({2'b00, exp});
    @(negedge ACLK);
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!S_AXI_ARREADY && n < 20);
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!S_AXI_RVALID && n < 20) begin @(negedge ACLK); n++; end
    e = rexp_q.pop_front();
    check({tag, "_rvalid_rresp"}, {29'd0, S_AXI_RVALID, S_AXI_RRESP}, {29'd0, 1'b1, e[33:32]});
    check({tag, "_rdata"}, S_AXI_RDATA, e[31:0]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          aw_seen;
    logic [33:0] e;
    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
    S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0; S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b0;
    repeat (3) @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    check("reset_outputs",
          {21'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID,
           oled_sclk, oled_sdin, oled_cs_n, oled_dc, oled_res_n, busy},
          {21'd0, 11'b00000_001000});
    check("reset_rdata", S_AXI_RDATA, 32'h0);

    // Write/readback sweep; the TXDATA write launches a D=1 transfer of 0x11.
    axi_write(5'h00, 32'h0101FFFF, 4'hF, "sweep_ctrl");
    check("res_n_after_ctrl", 32'(oled_res_n), 32'd1);
    axi_write(5'h04, 32'hABCD0001, 4'hF, "sweep_clkdiv");
    expect_frame(1'b0, 8'h11, 2);
    axi_write(5'h08, 32'hDEAD0011, 4'hF, "sweep_txdata");
    axi_write(5'h0C, 32'hBEEF0011, 4'hF, "sweep_scratch");
    axi_read(5'h00, 32'h0101FFFF, "rb_ctrl");
    axi_read(5'h04, 32'hABCD0001, "rb_clkdiv");
    axi_read(5'h08, 32'hDEAD0011, "rb_txdata");
    axi_read(5'h0C, 32'hBEEF0011, "rb_scratch");
    wait_frame("frame_sweep");

    // Fastest divider.
    axi_write(5'h00, 32'h1, 4'hF, "ctrl_en");
    axi_write(5'h04, 32'h0, 4'hF, "div0");
    expect_frame(1'b1, 8'hA5, 1);
    axi_write(5'h08, 32'h1A5, 4'hF, "tx_1a5");
    wait_frame("frame_a5");

    // D=3 gives an 8-cycle sclk period.
    axi_write(5'h04, 32'h3, 4'hF, "div3");
    expect_frame(1'b0, 8'h3C, 4);
    axi_write(5'h08, 32'h03C, 4'hF, "tx_03c");
    wait_frame("frame_3c");

    // Overflow and mid-transfer divider change.
    expect_frame(1'b0, 8'hC3, 4);
    axi_write(5'h08, 32'h0C3, 4'hF, "tx_0c3");
    axi_write(5'h04, 32'h0, 4'hF, "div_mid");
    axi_write(5'h08, 32'h155, 4'hF, "tx_overflow");
    axi_read(5'h10, 32'h3, "status_busy_ovf");
    axi_write(5'h10, 32'hFFFFFFFF, 4'hF, "status_clear");
    axi_read(5'h10, 32'h1, "status_busy_only");
    wait_frame("frame_c3");
    axi_read(5'h10, 32'h0, "status_idle");
    axi_read(5'h08, 32'h155, "rb_tx_after_ovf");

    // Disabled: TXDATA updates, nothing launches, no overflow.
    axi_write(5'h00, 32'h2, 4'hF, "ctrl_dis");
    axi_write(5'h08, 32'h1FF, 4'hF, "tx_disabled");
    repeat (10) @(negedge ACLK);
    check("disabled_no_launch", {30'd0, oled_cs_n, busy}, {30'd0, 2'b10});
    axi_read(5'h10, 32'h0, "status_disabled");
    axi_read(5'h08, 32'h1FF, "rb_tx_disabled");

    // Read and write accepted together; STATUS shows pre-launch busy.
    axi_write(5'h00, 32'h3, 4'hF, "ctrl_en2");
    expect_frame(1'b1, 8'h81, 1);
    fork
      axi_write(5'h08, 32'h181, 4'hF, "tx_concurrent");
      axi_read(5'h10, 32'h0, "status_concurrent");
    join
    wait_frame("frame_81");

    // Write response back-pressure with a second write pending.
    bresp_q.push_back(2'b00);
    @(negedge ACLK);
    S_AXI_AWADDR = 5'h0C; S_AXI_WDATA = 32'h12345678; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!S_AXI_AWREADY && n < 20);
    @(negedge ACLK);
    S_AXI_WDATA = 32'h0BADF00D;
    aw_seen = 0;
    for (int i = 0; i < 5; i++) begin
      check("bstall_bvalid", {29'd0, S_AXI_BVALID, S_AXI_BRESP}, {29'd0, 3'b100});
      if (S_AXI_AWREADY) aw_seen++;
      @(negedge ACLK);
    end
    check("bstall_no_second_aw", aw_seen, 0);
    S_AXI_BREADY = 1'b1;
    void'(bresp_q.pop_front());
    bresp_q.push_back(2'b00);
    n = 0;
    do begin @(negedge ACLK); n++; end while (!S_AXI_AWREADY && n < 20);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    n = 0;
    while (!S_AXI_BVALID && n < 20) begin @(negedge ACLK); n++; end
    check("second_write_bresp", {29'd0, S_AXI_BVALID, S_AXI_BRESP}, {29'd0, 1'b1, bresp_q.pop_front()});
    axi_read(5'h0C, 32'h0BADF00D, "rb_scratch2");

    // Read data back-pressure.
    rexp_q.push_back({2'b00, 32'h0BADF00D});
    @(negedge ACLK);
    S_AXI_ARADDR = 5'h0C; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!S_AXI_ARREADY && n < 20);
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    e = rexp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      check("rstall_rvalid", 32'(S_AXI_RVALID), 32'd1);
      check("rstall_rdata", S_AXI_RDATA, e[31:0]);
      @(negedge ACLK);
    end
    S_AXI_RREADY = 1'b1;
    @(negedge ACLK);
    check("rstall_released", 32'(S_AXI_RVALID), 32'd0);

    // Unmapped offsets.
    axi_read(5'h18, 32'h0, "rd_unmapped18");
    axi_write(5'h14, 32'hFFFFFFFF, 4'hF, "wr_unmapped14");
    axi_read(5'h14, 32'h0, "rd_unmapped14");

    // Reset mid-transfer aborts everything.
    axi_write(5'h04, 32'h3, 4'hF, "div3_abort");
    axi_write(5'h08, 32'h1AA, 4'hF, "tx_abort");
    repeat (20) @(negedge ACLK);
    check("abort_in_flight", {31'd0, busy}, {31'd0, 1'b1});
    ARESET = 1'b1;
    @(posedge ACLK);
    #1;
    check("abort_outputs", {26'd0, oled_sclk, oled_sdin, oled_cs_n, oled_dc, oled_res_n, busy},
          {26'd0, 6'b001000});
    @(negedge ACLK);
    ARESET = 1'b0;
    axi_read(5'h00, 32'h0, "abort_ctrl");
    axi_read(5'h04, 32'h0, "abort_clkdiv");
    axi_read(5'h08, 32'h0, "abort_txdata");
    axi_read(5'h0C, 32'h0, "abort_scratch");
    axi_read(5'h10, 32'h0, "abort_status");
    repeat (10) @(negedge ACLK);
    check("abort_no_frame", rx_q.size(), 0);
    check("leftover_expected", exp_fq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_oled_axil_slave.md
Name: spi_oled_axil_slave

Overview:
AXI4-Lite slave register file and SPI transmitter for the OLED panel. It answers the AXI4-Lite master, which is the processor or the BFM. Register writes configure the panel control lines and launch 9-bit (D/C + 8 data bits) mode-0 SPI transfers. It sits between the interconnect and the OLED pins. Every R/W register reads back exactly what was written, so the standard write/readback sweep over offsets 0x0-0xC passes.

Parameters:
ADDR_WIDTH, 5, AXI address bits used; decode on addr[4:2]
DATA_WIDTH, 32, AXI data width; fixed at 32
DIV_WIDTH, 8, width of the SCLK half-period divider field

Ports:
ACLK  in  1  single clock for AXI and SPI logic
ARESET  in  1  synchronous, active-high reset
S_AXI_AWADDR  in  ADDR_WIDTH  write address
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response, always 2'b00
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  ADDR_WIDTH  read address
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response, always 2'b00
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
oled_sclk  out  1  SPI clock, idles low
oled_sdin  out  1  SPI data, MSB first
oled_cs_n  out  1  chip select, active low
oled_dc  out  1  data/command select
oled_res_n  out  1  panel reset, active low
busy  out  1  SPI transfer in progress

Behaviour:
- Clock and reset: one clock ACLK. ARESET is synchronous and active-high.
- Reset values: all registers 0; AWREADY, WREADY, BVALID, ARREADY, RVALID = 0; RDATA = 0; oled_sclk = 0; oled_sdin = 0; oled_cs_n = 1; oled_dc = 0; oled_res_n = 0; busy = 0.
- Register map (offset): 0x00 CTRL R/W; 0x04 CLKDIV R/W; 0x08 TXDATA R/W; 0x0C SCRATCH R/W; 0x10 STATUS RO.
  - CTRL: bit0 = enable, bit1 drives oled_res_n.
  - CLKDIV: [DIV_WIDTH-1:0] = D, half-period H = D+1 ACLK cycles.
  - TXDATA: [7:0] = byte to send, [8] = D/C value for the transfer.
  - STATUS: bit0 = busy, bit1 = overflow (sticky), other bits 0.
  - 0x14-0x1C: writes ignored with OKAY response; reads return 0.
- Write channel:
  - AWREADY and WREADY pulse high together for one cycle when AWVALID && WVALID && !BVALID && !(AWREADY).
  - The register is updated per byte under WSTRB in the cycle after the handshake.
  - BVALID rises in that same following cycle and holds until BREADY. No new write is accepted while BVALID = 1.
- Read channel:
  - ARREADY pulses for one cycle when ARVALID && !RVALID && !ARREADY.
  - RVALID and RDATA follow on the next cycle. RDATA holds stable until RREADY.
- Launch:
  - A write to TXDATA with WSTRB[0] = 1, CTRL.enable = 1 and busy = 0 starts a transfer. busy rises in the same cycle BVALID rises.
  - The same write with busy = 1 updates TXDATA but does not launch, and sets overflow.
  - Any write to 0x10 clears overflow.
  - The same write with enable = 0 updates TXDATA only; no launch, no overflow.
- SPI FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE. A half-period counter reloads with D on each phase.
  - SETUP: 1 half-period. cs_n = 0; dc and sdin = bit7 are latched from TXDATA.
  - SHIFT: 16 half-periods, 8 bits. sclk rises at the end of each odd half and falls at the end of each even half. sdin changes on the falling edge, next bit MSB first.
  - HOLD: 1 half-period with sclk = 0. cs_n = 1 on return to IDLE.
  - Total transfer = 18*H cycles with busy = 1; busy = 0 in the cycle cs_n returns high.
- CLKDIV written mid-transfer takes effect only at the next transfer; H is latched at launch.
- ARESET mid-transfer aborts immediately to reset values; nothing partial is resumed.
- A read and a write in the same cycle are both accepted. A STATUS read returns the pre-write busy value.

Test Plan:
- Reset, then write 0x0101FFFF, 0xabcd0001, 0xdead0011, 0xbeef0011 to 0x0, 0x4, 0x8, 0xC and read each back -> every BRESP and RRESP = 00, readback equals the written value, oled_res_n = 1 after the CTRL write.
- CTRL = 1, CLKDIV = 0, write TXDATA = 0x1A5 -> busy high for exactly 18 cycles; dc = 1; sdin sampled on 8 rising sclk edges = 1,0,1,0,0,1,0,1; cs_n low throughout.
- CLKDIV = 3, write TXDATA = 0x03C -> sclk period = 8 ACLK cycles, busy for 72 cycles, dc = 0, bits = 0x3C.
- Write TXDATA during a transfer -> in-flight bits unchanged, STATUS read = 0x3; write 0x10 -> STATUS = 0x1, then 0x0 after done.
- Hold BREADY/RREADY low for 5 cycles -> BVALID/RVALID and RDATA held stable, no second AW accepted; read 0x18 -> RDATA = 0.
- Assert ARESET mid-transfer -> next cycle cs_n = 1, sclk = 0, busy = 0, all registers = 0.
